// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM control slice.
// Optional build macro used by this slice: DUTY_RAMP_BYPASS_EN (see pwm_duty_ramp).
package pwm_pkg;

  // Default duty-code width; the PWM width field uses these bits above its fixed LSB.
  localparam int DUTY_W_DEFAULT = 3;

  // Counter width of the downstream PWM period counter.
  localparam int CBITS = 18;

  typedef logic [DUTY_W_DEFAULT-1:0] duty_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Switch-bus synchroniser plus debounce counter.
// Produces the accepted (debounced) target code and a one-cycle strobe on each change.
module sw_debounce
  import pwm_pkg::*;
#(
  parameter int DUTY_W          = DUTY_W_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] sw_raw,
  output logic [DUTY_W-1:0] target,
  output logic              upd
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Count value at which the next agreeing sample completes the stable window.
  localparam logic [CW-1:0] DCNT_ACC = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] DCNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [DUTY_W-1:0] sync_q [SYNC_STAGES];
  logic [DUTY_W-1:0] sw_sync;
  logic [DUTY_W-1:0] cand;
  logic [CW-1:0]     dcnt;
  logic              accept;

  // Saturating increment for the stability counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == DCNT_MAX) ? v : v + 1'b1;
  endfunction

  assign sw_sync = sync_q[SYNC_STAGES-1];

  // The sample on this cycle agrees with the candidate and closes a window of
  // DEBOUNCE_CYCLES consecutive identical synchronised samples.
  assign accept = (sw_sync == cand) &&
                  ((dcnt == DCNT_ACC) || (dcnt == DCNT_MAX)) &&
                  (cand != target);

  // Synchroniser chain: stage 0 captures the asynchronous switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Candidate tracking and stability counting; any disagreement restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      dcnt <= '0;
    end else if (sw_sync != cand) begin
      cand <= sw_sync;
      dcnt <= '0;
    end else begin
      dcnt <= sat_inc(dcnt);
    end
  end

  // Accepted target register and its change strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      upd    <= 1'b0;
    end else begin
      upd <= accept;
      if (accept) target <= cand;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-code slew controller for the PWM generator.
// Debounces the duty switches into target_code and moves duty_code toward it one LSB
// every RAMP_PERIODS PWM periods, changing only on period_start (glitch-free widths).
// Build macro DUTY_RAMP_BYPASS_EN: when defined, duty_code jumps straight to the target
// on the first period_start after a mismatch instead of ramping.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int DUTY_W          = DUTY_W_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAMP_PERIODS    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] sw_raw,
  input  logic              period_start,
  output logic [DUTY_W-1:0] duty_code,
  output logic [DUTY_W-1:0] target_code,
  output logic              settled,
  output logic              step_pulse
);

  localparam int PW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(RAMP_PERIODS - 1);

  ramp_state_t       state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              step_d;
  logic              tgt_upd;

  // One LSB toward the target; unsigned compare keeps the code from wrapping.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] d,
                                                    input logic [DUTY_W-1:0] t);
    if (t > d)      return d + 1'b1;
    else if (t < d) return d - 1'b1;
    else            return d;
  endfunction

  sw_debounce #(
    .DUTY_W          (DUTY_W),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .target (target_code),
    .upd    (tgt_upd)
  );

  // Ramp FSM next-state: IDLE waits for a mismatch, RAMP steps on period boundaries.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    duty_d  = duty_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        pcnt_d = '0;
        // A fresh target or any leftover mismatch starts a ramp.
        if (tgt_upd || (target_code != duty_q)) state_d = RAMP;
      end
      RAMP: begin
        if (target_code == duty_q) begin
          // Target moved back onto the current code: stop without stepping.
          state_d = IDLE;
          pcnt_d  = '0;
        end else if (period_start) begin
`ifdef DUTY_RAMP_BYPASS_EN
          duty_d  = target_code;
          step_d  = 1'b1;
          state_d = IDLE;
          pcnt_d  = '0;
`else
          if (pcnt_q == PCNT_LAST) begin
            duty_d = step_toward(duty_q, target_code);
            pcnt_d = '0;
            step_d = 1'b1;
            if (duty_d == target_code) state_d = IDLE;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        pcnt_d  = '0;
      end
    endcase
  end

  // Ramp FSM state, period counter, delivered duty code and step strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      duty_q     <= '0;
      step_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      duty_q     <= duty_d;
      step_pulse <= step_d;
    end
  end

  assign duty_code = duty_q;
  assign settled   = (state_q == IDLE) && (duty_q == target_code);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp with a behavioural reference model.
module tb_pwm_duty_ramp;

  localparam int DW   = 3;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int RP   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sw_raw = '0;
  logic          period_start = 1'b0;
  logic [DW-1:0] duty_code, target_code;
  logic          settled, step_pulse;

  int total = 0;
  int bad   = 0;

  int ps_every = 8;   // 0: no period_start, 1: continuous, N: one pulse every N cycles
  int ps_ctr   = 0;

  pwm_duty_ramp #(
    .DUTY_W          (DW),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .RAMP_PERIODS    (RP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_raw       (sw_raw),
    .period_start (period_start),
    .duty_code    (duty_code),
    .target_code  (target_code),
    .settled      (settled),
    .step_pulse   (step_pulse)
  );

  always #5 clk = ~clk;

  // period_start generator, driven just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ps_every <= 0) begin
        period_start = 1'b0;
      end else if (ps_every == 1) begin
        period_start = 1'b1;
      end else begin
        period_start = (ps_ctr == 0);
        ps_ctr = (ps_ctr >= ps_every - 1) ? 0 : ps_ctr + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Switch value history, run length of identical synchronised samples,
  // accepted target, delivered duty and a "ramp in progress" flag.
  logic [DW-1:0] m_hist [SYNC];
  logic [DW-1:0] m_prev, m_tgt, m_duty, m_s, m_old_tgt;
  int            m_run;
  bit            m_busy, m_step, ps_at_edge;
  int            m_periods;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
      m_prev = '0; m_tgt = '0; m_duty = '0;
      m_run = 1; m_busy = 0; m_step = 0; m_periods = 0; ps_at_edge = 0;
    end else begin
      ps_at_edge = period_start;
      m_s = m_hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = sw_raw;
      m_run  = (m_s == m_prev) ? ((m_run < DEB) ? m_run + 1 : DEB) : 1;
      m_prev = m_s;
      m_old_tgt = m_tgt;
      if (m_run >= DEB && m_s != m_tgt) m_tgt = m_s;
      m_step = 0;
      if (!m_busy) begin
        m_periods = 0;
        if (m_old_tgt != m_duty) m_busy = 1;
      end else if (m_old_tgt == m_duty) begin
        m_busy = 0;
        m_periods = 0;
      end else if (period_start) begin
`ifdef DUTY_RAMP_BYPASS_EN
        m_duty = m_old_tgt;
        m_step = 1;
        m_busy = 0;
`else
        m_periods++;
        if (m_periods == RP) begin
          m_periods = 0;
          m_step = 1;
          if (m_old_tgt > m_duty) m_duty = m_duty + 1'b1;
          else m_duty = m_duty - 1'b1;
          if (m_duty == m_old_tgt) m_busy = 0;
        end
`endif
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sw_raw = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_raw = '0;
    ps_every = 8;
    #3;
    total++;
    if (duty_code !== 3'd0 || target_code !== 3'd0 || settled !== 1'b1 || step_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_during: duty=%0d target=%0d settled=%b step=%b, want 0 0 1 0",
               duty_code, target_code, settled, step_pulse);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      total++;
      if (duty_code !== 3'd0 || target_code !== 3'd0 || settled !== 1'b1 || step_pulse !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc %0d: duty=%0d target=%0d settled=%b step=%b, want 0 0 1 0",
                 c, duty_code, target_code, settled, step_pulse);
      end
    end
  endtask

  task automatic test_ramp_up();
    int n;
    int nsteps;
    int last_t;
    logic [DW-1:0] last;
    do_reset();
    ps_every = 8;
    @(posedge clk); #1;
    sw_raw = 3'b011;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); n++;
      #1;
      if (target_code == 3'd3) break;
    end
    total++;
    if (n !== 18 || target_code !== 3'd3) begin
      bad++;
      $display("FAIL ramp_target_latency: cycles=%0d target=%0d, want 18 and 3", n, target_code);
    end
    total++;
    if (settled !== 1'b0) begin
      bad++;
      $display("FAIL ramp_settled_drop: settled=%b want 0", settled);
    end
    nsteps = 0; last = 3'd0; last_t = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      total++;
      if (step_pulse !== m_step || settled !== (!m_busy && m_duty == m_tgt)) begin
        bad++;
        $display("FAIL ramp_ctrl cyc %0d: step=%b settled=%b, want %b %b",
                 c, step_pulse, settled, m_step, (!m_busy && m_duty == m_tgt));
      end
      if (duty_code !== last) begin
        nsteps++;
        total++;
        if (duty_code !== last + 3'd1 || step_pulse !== 1'b1 || ps_at_edge !== 1'b1) begin
          bad++;
          $display("FAIL ramp_step %0d: duty=%0d step=%b ps=%b, want %0d 1 1",
                   nsteps, duty_code, step_pulse, ps_at_edge, last + 3'd1);
        end
        if (nsteps > 1) begin
          total++;
          if (c - last_t !== 32) begin
            bad++;
            $display("FAIL ramp_spacing: %0d cycles between steps, want 32", c - last_t);
          end
        end
        last = duty_code;
        last_t = c;
      end
    end
    total++;
    if (nsteps !== 3 || duty_code !== 3'd3 || settled !== 1'b1) begin
      bad++;
      $display("FAIL ramp_final: steps=%0d duty=%0d settled=%b, want 3 3 1",
               nsteps, duty_code, settled);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    do_reset();
    ps_every = 8;
    @(posedge clk); #1;
    sw_raw = 3'b111;
    repeat (10) @(posedge clk);
    #1 sw_raw = 3'b000;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (step_pulse === 1'b1) pulses++;
      total++;
      if (target_code !== 3'd0) begin
        bad++;
        $display("FAIL glitch_target cyc %0d: target=%0d want 0", c, target_code);
      end
    end
    total++;
    if (pulses !== 0 || duty_code !== 3'd0 || settled !== 1'b1) begin
      bad++;
      $display("FAIL glitch_quiet: pulses=%0d duty=%0d settled=%b, want 0 0 1",
               pulses, duty_code, settled);
    end
  endtask

  task automatic test_retarget();
    bit hit;
    logic [DW-1:0] maxd;
    logic [DW-1:0] after2;
    bit seen_after;
    do_reset();
    ps_every = 8;
    @(posedge clk); #1;
    sw_raw = 3'b111;
    hit = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (duty_code == 3'd2) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL retarget_reach2: duty=%0d want 2 within bound", duty_code);
    end
    sw_raw = 3'b001;
    maxd = duty_code; seen_after = 0; after2 = 3'd2;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (duty_code > maxd) maxd = duty_code;
      if (!seen_after && duty_code != 3'd2) begin seen_after = 1; after2 = duty_code; end
      total++;
      if (duty_code !== m_duty) begin
        bad++;
        $display("FAIL retarget_model cyc %0d: duty=%0d want %0d", c, duty_code, m_duty);
      end
    end
    total++;
    if (maxd !== 3'd2 || after2 !== 3'd1 || duty_code !== 3'd1 || settled !== 1'b1) begin
      bad++;
      $display("FAIL retarget_final: max=%0d next=%0d duty=%0d settled=%b, want 2 1 1 1",
               maxd, after2, duty_code, settled);
    end
  endtask

  task automatic test_reset_mid_ramp();
    bit hit;
    do_reset();
    ps_every = 8;
    @(posedge clk); #1;
    sw_raw = 3'b111;
    hit = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (duty_code == 3'd5) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL midreset_reach5: duty=%0d want 5 within bound", duty_code);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (duty_code !== 3'd0 || target_code !== 3'd0 || settled !== 1'b1 || step_pulse !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: duty=%0d target=%0d settled=%b step=%b, want 0 0 1 0",
               duty_code, target_code, settled, step_pulse);
    end
    sw_raw = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 39) == 0) sw_raw = DW'($urandom);
      if ($urandom_range(0, 299) == 0) ps_every = int'($urandom_range(0, 8));
      @(negedge clk);
      total++;
      if (duty_code !== m_duty || target_code !== m_tgt || step_pulse !== m_step ||
          settled !== (!m_busy && m_duty == m_tgt)) begin
        bad++;
        $display("FAIL random cyc %0d: duty=%0d tgt=%0d step=%b set=%b, want %0d %0d %b %b",
                 c, duty_code, target_code, step_pulse, settled,
                 m_duty, m_tgt, m_step, (!m_busy && m_duty == m_tgt));
      end
    end
    ps_every = 8;
  endtask

`ifdef DUTY_RAMP_BYPASS_EN
  task automatic test_bypass();
    int pulses;
    bit hit;
    do_reset();
    ps_every = 8;
    @(posedge clk); #1;
    sw_raw = 3'b110;
    hit = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (target_code == 3'd6) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL bypass_target: target=%0d want 6", target_code);
    end
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (step_pulse === 1'b1) begin
        pulses++;
        total++;
        if (duty_code !== 3'd6 || ps_at_edge !== 1'b1) begin
          bad++;
          $display("FAIL bypass_jump: duty=%0d ps=%b, want 6 1", duty_code, ps_at_edge);
        end
      end
    end
    total++;
    if (pulses !== 1 || duty_code !== 3'd6 || settled !== 1'b1) begin
      bad++;
      $display("FAIL bypass_final: pulses=%0d duty=%0d settled=%b, want 1 6 1",
               pulses, duty_code, settled);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DUTY_RAMP_BYPASS_EN
    test_bypass();
`else
    test_ramp_up();
    test_glitch();
    test_retarget();
    test_reset_mid_ramp();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
